// File: rtl/serial_sub.sv
// serial_sub: bit-serial borrow-ripple subtractor, Diff = X - Y - Bin.
// One full-subtractor cell processes one bit per clock, LSB first, under a
// start/busy/done handshake. One result is available every WIDTH+2 cycles.
// Optional feature: define SERIAL_SUB_OVF_EN to build the signed-overflow
// flag Ovf. Without it, Ovf is tied low and no extra register is built.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out,
    output logic             Ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] sr;
    logic             b;
    logic             d;
    logic             bn;

    // Single full-subtractor cell working on the current LSBs and the borrow.
    always_comb begin
        d  = xr[0] ^ yr[0] ^ b;
        bn = (~xr[0] & yr[0]) | (~(xr[0] ^ yr[0]) & b);
    end

    // Control FSM together with the operand/result shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            xr    <= '0;
            yr    <= '0;
            sr    <= '0;
            b     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= X;
                        yr    <= Y;
                        b     <= Bin;
                        cnt   <= '0;
                        sr    <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= {d, sr[WIDTH-1:1]};
                    xr <= xr >> 1;
                    yr <= yr >> 1;
                    b  <= bn;
                    // Counter stops at its last value so it never wraps.
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == DONE);

    // Result registers: loaded only in DONE, with a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            Diff  <= '0;
            B_out <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                Diff  <= sr;
                B_out <= b;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic b_msb;

    // Borrow into the MSB is the borrow register during the last SHIFT cycle;
    // overflow is its disagreement with the borrow out of the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            if ((state == SHIFT) && (cnt == LAST)) begin
                b_msb <= b;
            end
            if (state == DONE) begin
                Ovf <= b_msb ^ b;
            end
        end
    end
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed cases, exhaustive 4-bit sweep and random
// operations checked against an arithmetic reference model.
module tb_serial_sub;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         B_out;
    logic         Ovf;

    int tests  = 0;
    int failed = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .B_out (B_out),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic int model_diff(input int x, input int y, input int bi);
        int r;
        r = x - y - bi;
        return ((r % M) + M) % M;
    endfunction

    function automatic logic model_borrow(input int x, input int y, input int bi);
        return (x < y + bi);
    endfunction

    function automatic logic model_ovf(input int x, input int y, input int bi);
`ifdef SERIAL_SUB_OVF_EN
        int sx;
        int sy;
        int r;
        sx = (x >= M / 2) ? x - M : x;
        sy = (y >= M / 2) ? y - M : y;
        r  = sx - sy - bi;
        return (r < -(M / 2)) || (r > (M / 2) - 1);
`else
        return 1'b0;
`endif
    endfunction

    // One operation: start sampled at the next edge k, done expected exactly
    // once, after edge k+W+1; 'extra' idle cycles are watched afterwards.
    task automatic do_op(input int x, input int y, input int bi, input int extra);
        int got_at;
        int pulses;
        X     = W'(x);
        Y     = W'(y);
        Bin   = bi[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL op_busy x=%0d y=%0d b=%0d: busy=%b want 1", x, y, bi, busy);
        end
        got_at = -1;
        pulses = 0;
        for (int n = 1; n <= W + 1 + extra; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (got_at < 0) got_at = n;
            end
        end
        tests++;
        if (got_at != W + 1) begin
            failed++;
            $display("FAIL op_latency x=%0d y=%0d b=%0d: done at cycle %0d want %0d", x, y, bi, got_at, W + 1);
        end
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL op_pulses x=%0d y=%0d b=%0d: %0d done pulses want 1", x, y, bi, pulses);
        end
        tests++;
        if (Diff !== W'(model_diff(x, y, bi))) begin
            failed++;
            $display("FAIL op_diff x=%0d y=%0d b=%0d: Diff=%0d want %0d", x, y, bi, Diff, model_diff(x, y, bi));
        end
        tests++;
        if (B_out !== model_borrow(x, y, bi)) begin
            failed++;
            $display("FAIL op_borrow x=%0d y=%0d b=%0d: B_out=%b want %b", x, y, bi, B_out, model_borrow(x, y, bi));
        end
        tests++;
        if (Ovf !== model_ovf(x, y, bi)) begin
            failed++;
            $display("FAIL op_ovf x=%0d y=%0d b=%0d: Ovf=%b want %b", x, y, bi, Ovf, model_ovf(x, y, bi));
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({busy, done, Diff, B_out, Ovf} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: busy=%b done=%b Diff=%0d B_out=%b Ovf=%b want all 0",
                     busy, done, Diff, B_out, Ovf);
        end
    endtask

    task automatic test_directed();
        do_op(9, 3, 0, 2);
        tests++;
        if (Diff !== 4'd6 || B_out !== 1'b0) begin
            failed++;
            $display("FAIL dir_9_3: Diff=%0d B_out=%b want 6 0", Diff, B_out);
        end
        do_op(3, 9, 0, 2);
        tests++;
        if (Diff !== 4'd10 || B_out !== 1'b1) begin
            failed++;
            $display("FAIL dir_3_9: Diff=%0d B_out=%b want 10 1", Diff, B_out);
        end
        do_op(0, 0, 1, 2);
        tests++;
        if (Diff !== 4'd15 || B_out !== 1'b1) begin
            failed++;
            $display("FAIL dir_0_0_1: Diff=%0d B_out=%b want 15 1", Diff, B_out);
        end
    endtask

    task automatic test_sweep();
        logic [8:0] v;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            do_op(int'(v[8:5]), int'(v[4:1]), int'(v[0]), 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                  int'($urandom_range(1)), int'($urandom_range(2)));
        end
    endtask

    // Ops issued at the earliest legal edge, one right after another.
    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_op(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                  int'($urandom_range(1)), 0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // start held through the whole busy window including DONE; operands
    // changed after capture must not affect the result.
    task automatic test_hold_start();
        int pulses;
        X     = 4'd5;
        Y     = 4'd2;
        Bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        X      = 4'd15;
        Y      = 4'd0;
        pulses = 0;
        for (int n = 1; n <= W + 8; n++) begin
            @(posedge clk);
            #1;
            if (n == W + 1) start = 1'b0;
            if (done === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL hold_pulses: %0d done pulses want 1", pulses);
        end
        tests++;
        if (Diff !== 4'd3 || B_out !== 1'b0) begin
            failed++;
            $display("FAIL hold_result: Diff=%0d B_out=%b want 3 0", Diff, B_out);
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL hold_idle: busy=%b want 0", busy);
        end
    endtask

    // Reset during the second SHIFT cycle aborts the op.
    task automatic test_rst_mid();
        int pulses;
        X     = 4'd12;
        Y     = 4'd4;
        Bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({busy, done, Diff, B_out, Ovf} !== '0) begin
            failed++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b Diff=%0d B_out=%b Ovf=%b want all 0",
                     busy, done, Diff, B_out, Ovf);
        end
        pulses = 0;
        for (int n = 0; n < W + 4; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0 || Diff !== 4'd0) begin
            failed++;
            $display("FAIL rst_mid_nodone: %0d pulses Diff=%0d want 0 0", pulses, Diff);
        end
        do_op(7, 7, 0, 1);
        tests++;
        if (Diff !== 4'd0 || B_out !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_next: Diff=%0d B_out=%b want 0 0", Diff, B_out);
        end
    endtask

    // rst and start together: rst wins, no operation begins.
    task automatic test_rst_start();
        X     = 4'd9;
        Y     = 4'd1;
        Bin   = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL rst_start_busy: busy=%b want 0", busy);
        end
        repeat (W + 3) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || Diff !== 4'd0) begin
            failed++;
            $display("FAIL rst_start_idle: done=%b Diff=%0d want 0 0", done, Diff);
        end
    endtask

    task automatic test_ovf();
        logic want_a;
        logic want_b;
`ifdef SERIAL_SUB_OVF_EN
        want_a = 1'b1;
`else
        want_a = 1'b0;
`endif
        want_b = 1'b0;
        do_op(8, 1, 0, 1);
        tests++;
        if (Diff !== 4'd7 || Ovf !== want_a) begin
            failed++;
            $display("FAIL ovf_8_1: Diff=%0d Ovf=%b want 7 %b", Diff, Ovf, want_a);
        end
        do_op(6, 2, 0, 1);
        tests++;
        if (Ovf !== want_b) begin
            failed++;
            $display("FAIL ovf_6_2: Ovf=%b want %b", Ovf, want_b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_random();
        test_back_to_back();
        test_hold_start();
        test_rst_mid();
        test_rst_start();
        test_ovf();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
